// File: rtl/fpaddsub_stream_ctrl.sv
// rtl/fpaddsub_stream_ctrl.sv - stream front/back end with credit-guarded result FIFO for the FP add/sub core
module fpaddsub_stream_ctrl #(
  parameter int LATENCY    = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic             core_ctrl,
  input  logic [31:0]      core_z,
  input  logic [4:0]       core_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_z,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       flag_acc,
  input  logic             flag_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int OW = AW + 1;
  localparam int CW = ((IW > OW) ? IW : OW) + 1;
  localparam int EW = 32 + 5 + TAG_W;

  logic             accept;
  logic             push;
  logic             pop;
  logic [CW-1:0]    credit_used;

  logic [LATENCY-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [4:0]         flag_acc_q, flag_acc_d;

  // Credits: every accepted op owns a FIFO slot from issue until it is popped
  always_comb begin
    credit_used = CW'(inflight_q) + CW'(occ_q);
    in_ready    = rst & (credit_used < CW'(FIFO_DEPTH));
    accept      = in_valid & in_ready;
    push        = vld_q[LATENCY-1];
    out_valid   = (occ_q != '0);
    pop         = out_valid & out_ready;
    core_a      = accept ? in_a  : 32'd0;
    core_b      = accept ? in_b  : 32'd0;
    core_ctrl   = accept ? in_op : 1'b0;
  end

  assign {out_z, out_flags, out_tag} = mem_q[rd_ptr_q];
  assign flag_acc = flag_acc_q;

  // Next-state counters and sticky flag accumulator; a clear coinciding with a pop keeps the popped flags
  always_comb begin
    inflight_d = inflight_q + IW'(accept) - IW'(push);
    occ_d      = occ_q + OW'(push) - OW'(pop);
    flag_acc_d = flag_acc_q;
    if (flag_clr) flag_acc_d = 5'd0;
    if (pop)      flag_acc_d = flag_acc_d | out_flags;
  end

  // Tracking pipeline mirrors the core; clearing it on reset discards results still in the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[LATENCY-2:0], accept};
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Result FIFO storage, pointers and counters; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      flag_acc_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {core_z, core_flags, tag_q[LATENCY-1]};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      flag_acc_q <= flag_acc_d;
    end
  end

endmodule

// File: tb/tb_fpaddsub_stream_ctrl.sv
// tb/tb_fpaddsub_stream_ctrl.sv - self-checking bench for fpaddsub_stream_ctrl
module tb_fpaddsub_stream_ctrl;

  localparam int LAT   = 11;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [31:0] core_a, core_b, core_z;
  logic        core_ctrl;
  logic [4:0]  core_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic [4:0]  out_flags, flag_acc;
  logic [3:0]  out_tag;
  logic        flag_clr;

  fpaddsub_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_tag(in_tag),
    .core_a(core_a), .core_b(core_b), .core_ctrl(core_ctrl),
    .core_z(core_z), .core_flags(core_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_flags(out_flags), .out_tag(out_tag),
    .flag_acc(flag_acc), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  // Stand-in arithmetic core: exact IEEE results for the directed operands, an opaque mix otherwise
  function automatic logic [36:0] ref_core(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return {32'h40400000, 5'b00000};
    if (a == 32'h40400000 && b == 32'h3F800000 &&  op) return {32'h40000000, 5'b00000};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && !op) return {32'h7F800000, 5'b10001};
    return {a ^ {b[15:0], b[31:16]} ^ {31'd0, op}, a[4:0] ^ b[6:2]};
  endfunction

  // Non-resettable fixed-latency core pipeline
  logic [36:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= ref_core(core_a, core_b, core_ctrl);
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign {core_z, core_flags} = cpipe[LAT-1];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
    logic [3:0]  tag;
    int          due;
  } ent_t;

  ent_t       sbq[$];
  logic [4:0] exp_acc;
  int         errors = 0;
  int         checks = 0;
  int         n_acc  = 0;
  int         n_pop  = 0;
  logic       last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample just after the falling edge, score the handshakes, advance to the next falling edge
  task automatic tick();
    logic       acc, pp;
    logic [36:0] r;
    ent_t       e;
    #1;
    if (!rst) begin
      sbq.delete();
      exp_acc = 5'd0;
    end
    chk("in_ready", in_ready, (rst && sbq.size() < DEPTH));
    chk("out_valid", out_valid, (sbq.size() != 0 && sbq[0].due <= edge_cnt));
    chk("flag_acc", flag_acc, exp_acc);
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (flag_clr) exp_acc = 5'd0;
    if (pp && sbq.size() != 0) begin
      chk("out_z", out_z, sbq[0].z);
      chk("out_flags", out_flags, sbq[0].f);
      chk("out_tag", out_tag, sbq[0].tag);
      exp_acc = exp_acc | sbq[0].f;
      void'(sbq.pop_front());
      n_pop++;
    end
    if (acc) begin
      r     = ref_core(in_a, in_b, in_op);
      e.z   = r[36:5];
      e.f   = r[4:0];
      e.tag = in_tag;
      e.due = edge_cnt + 1 + LAT;
      sbq.push_back(e);
      n_acc++;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tg);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tg;
  endtask

  task automatic set_rand(input logic [3:0] tg);
    set_op($urandom, $urandom, 1'($urandom_range(0, 1)), tg);
  endtask

  initial begin
    int         lat, base_acc, base_pop;
    logic [3:0] tg;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
    out_ready = 1'b0; flag_clr = 1'b0; exp_acc = 5'd0; last_acc = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flag_acc", flag_acc, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1+2 with tag 3, consumer always ready
    out_ready = 1'b1;
    set_op(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
    tick();
    in_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("t1_popped", n_pop, 1);

    // 3-1: out_valid rises exactly LAT edges after the accepting edge
    out_ready = 1'b0;
    set_op(32'h40400000, 32'h3F800000, 1'b1, 4'd7);
    tick();
    chk("t2_accepted", last_acc, 1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk("t2_latency", lat, LAT);
    out_ready = 1'b1;
    tick();
    chk("t2_popped", n_pop, 2);

    // Back-pressure: exactly DEPTH ops accepted, then drained in order
    out_ready = 1'b0;
    base_acc = n_acc;
    base_pop = n_pop;
    tg = 4'd0;
    for (int i = 0; i < 40; i++) begin
      set_rand(tg);
      tick();
      if (last_acc) tg = tg + 4'd1;
    end
    chk("t3_accepted", n_acc - base_acc, DEPTH);
    chk("t3_full_ready", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();
    chk("t3_drained", n_pop - base_pop, DEPTH);
    chk("t3_ready_back", in_ready, 1);

    // Overflow sets the sticky OF bit; a later clean result keeps it; clear drops it
    set_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd9);
    tick();
    set_op(32'h3F800000, 32'h40000000, 1'b0, 4'd10);
    tick();
    in_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("t4_of_sticky", flag_acc[4], 1);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("t4_cleared", flag_acc, 0);

    // Reset mid-stream discards in-flight work
    for (int i = 0; i < 2; i++) begin
      set_rand(4'(i));
      tick();
    end
    rst = 1'b0;
    set_rand(4'd2);
    #0;
    chk("t5_rst_ready", in_ready, 0);
    tick();
    chk("t5_rst_valid", out_valid, 0);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    base_pop = n_pop;
    set_op(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    tick();
    in_valid = 1'b0;
    repeat (LAT + 10) tick();
    chk("t5_only_one", n_pop - base_pop, 1);

    // Full FIFO then sustained stream with simultaneous push/pop
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      set_rand(4'($urandom));
      tick();
    end
    out_ready = 1'b1;
    set_rand(4'($urandom));
    tick();
    base_acc = n_acc;
    base_pop = n_pop;
    for (int i = 0; i < 70; i++) begin
      set_rand(4'($urandom));
      flag_clr = (i == 30);
      tick();
    end
    flag_clr = 1'b0;
    chk("t6_throughput_in", n_acc - base_acc, 70);
    chk("t6_throughput_out", n_pop - base_pop, 70);
    in_valid = 1'b0;
    repeat (LAT + DEPTH + 4) tick();
    chk("t6_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
